// File: rtl/enigma_console_host.sv
// enigma_console_host
// Scripted host-side initiator for the Enigma UART console. It plays the PC's
// role over a byte-level UART handshake: loads the plugboard pairs, walks the
// menu (P / pairs / X / S / letters / ESC), checks prompts and echoes, and
// reports every ciphertext letter that comes back.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   start, sync_menu              run request (pulse), wait for '>' first
//   cfg_wr/sel/idx/a/b            pair (sel=0) / text (sel=1) memory writes
//   num_pairs, text_len           run lengths, sampled at start
//   tx_data, tx_start             byte and one-cycle send strobe to uart_tx
//   tx_active, tx_done            transmitter busy / byte finished
//   rx_data, rx_done              received byte, rising edge = new byte
//   ct_valid, ct_char, ct_idx     ciphertext letter strobe, code, position
//   busy, done, error, err_code   run status (1 timeout, 2 echo, 3 ct, 4 cfg)
//
// state        | meaning
// IDLE         | waiting for start
// CHECK        | validate lengths and pair letters, one pair per cycle
// WAIT_MENU0   | optional wait for the initial '>' prompt
// SEND_P       | send 'P'
// WAIT_PLUG    | wait for ':'
// SEND_A/B     | send first/second letter of pair k
// WAIT_ECHO_A/B| first byte back must equal the byte just sent
// SEND_X       | leave plugboard entry
// WAIT_MENU1   | wait for '>'
// SEND_S       | enter crypt mode
// WAIT_CRYPT   | wait for ':'
// SEND_PT      | send plaintext letter k
// WAIT_CT      | first byte back is the ciphertext letter
// SEND_ESC     | leave crypt mode
// WAIT_MENU2   | wait for '>'
// DONE         | success, back to IDLE
// ERROR        | failure, back to IDLE
module enigma_console_host #(
  parameter int MAX_PAIRS      = 13,
  parameter int MAX_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sync_menu,
  input  logic       cfg_wr,
  input  logic       cfg_sel,
  input  logic [7:0] cfg_idx,
  input  logic [4:0] cfg_a,
  input  logic [4:0] cfg_b,
  input  logic [7:0] num_pairs,
  input  logic [7:0] text_len,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_active,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       ct_valid,
  output logic [4:0] ct_char,
  output logic [7:0] ct_idx,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] err_code
);
  localparam int PW = (MAX_PAIRS > 1) ? $clog2(MAX_PAIRS) : 1;
  localparam int LW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_Z     = 8'h5A;
  localparam logic [7:0] CH_GT    = 8'h3E;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_P     = 8'h50;
  localparam logic [7:0] CH_X     = 8'h58;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_ESC   = 8'h1B;

  typedef enum logic [4:0] {
    S_IDLE, S_CHECK, S_WAIT_MENU0, S_SEND_P, S_WAIT_PLUG, S_SEND_A,
    S_WAIT_ECHO_A, S_SEND_B, S_WAIT_ECHO_B, S_SEND_X, S_WAIT_MENU1,
    S_SEND_S, S_WAIT_CRYPT, S_SEND_PT, S_WAIT_CT, S_SEND_ESC,
    S_WAIT_MENU2, S_DONE, S_ERROR
  } state_t;

  logic [4:0] pair_a   [MAX_PAIRS];
  logic [4:0] pair_b   [MAX_PAIRS];
  logic [4:0] text_mem [MAX_LEN];

  state_t        state, state_d;
  logic [7:0]    k, k_d;
  logic [7:0]    np_q, np_d, tl_q, tl_d;
  logic          sync_q, sync_d;
  logic          tx_sent, tx_sent_d;
  logic [TW-1:0] cnt, cnt_d;
  logic          rx_done_q, new_rx, pend, consume, clr_pend;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_data_d, ct_idx_d;
  logic          tx_start_d, ct_valid_d, busy_d, done_d, error_d;
  logic [4:0]    ct_char_d;
  logic [2:0]    err_code_d, fail_code;
  logic          fail, is_send, is_wait;
  logic [7:0]    send_byte;
  state_t        send_next;

  assign new_rx   = rx_done & ~rx_done_q;
  assign clr_pend = (state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (cfg_wr && !busy) begin
      if (!cfg_sel && cfg_idx < 8'(MAX_PAIRS)) begin
        pair_a[cfg_idx[PW-1:0]] <= cfg_a;
        pair_b[cfg_idx[PW-1:0]] <= cfg_b;
      end else if (cfg_sel && cfg_idx < 8'(MAX_LEN)) begin
        text_mem[cfg_idx[LW-1:0]] <= cfg_a;
      end
    end
  end

  always_comb begin
    state_d    = state;
    k_d        = k;
    np_d       = np_q;
    tl_d       = tl_q;
    sync_d     = sync_q;
    tx_sent_d  = tx_sent;
    cnt_d      = cnt;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    ct_valid_d = 1'b0;
    ct_char_d  = ct_char;
    ct_idx_d   = ct_idx;
    busy_d     = busy;
    done_d     = done;
    error_d    = error;
    err_code_d = err_code;
    consume    = 1'b0;
    fail       = 1'b0;
    fail_code  = 3'd0;
    is_send    = 1'b0;
    is_wait    = 1'b0;
    send_byte  = 8'h00;
    send_next  = state;

    case (state)
      S_IDLE: if (start) begin
        np_d = num_pairs; tl_d = text_len; sync_d = sync_menu;
        done_d = 1'b0; error_d = 1'b0; err_code_d = 3'd0; busy_d = 1'b1;
        k_d = 8'd0; state_d = S_CHECK;
      end
      S_CHECK: begin
        if (np_q > 8'(MAX_PAIRS) || tl_q > 8'(MAX_LEN)) begin
          fail = 1'b1; fail_code = 3'd4;
        end else if (k < np_q) begin
          if (pair_a[k[PW-1:0]] > 5'd25 || pair_b[k[PW-1:0]] > 5'd25) begin
            fail = 1'b1; fail_code = 3'd4;
          end else k_d = k + 8'd1;
        end else begin
          k_d = 8'd0; cnt_d = '0;
          if (sync_q) state_d = S_WAIT_MENU0;
          else state_d = (np_q == 8'd0) ? S_SEND_S : S_SEND_P;
        end
      end
      S_WAIT_MENU0: begin
        is_wait = 1'b1;
        if (pend) begin
          consume = 1'b1;
          if (rx_byte == CH_GT) state_d = (np_q == 8'd0) ? S_SEND_S : S_SEND_P;
        end
      end
      S_SEND_P: begin is_send = 1'b1; send_byte = CH_P; send_next = S_WAIT_PLUG; end
      S_WAIT_PLUG: begin
        is_wait = 1'b1;
        if (pend) begin
          consume = 1'b1;
          if (rx_byte == CH_COLON) begin k_d = 8'd0; state_d = S_SEND_A; end
        end
      end
      S_SEND_A: begin
        is_send = 1'b1; send_next = S_WAIT_ECHO_A;
        send_byte = {3'b000, pair_a[k[PW-1:0]]} + CH_A;
      end
      S_WAIT_ECHO_A: begin
        is_wait = 1'b1;
        if (pend) begin
          consume = 1'b1;
          if (rx_byte == tx_data) state_d = S_SEND_B;
          else begin fail = 1'b1; fail_code = 3'd2; end
        end
      end
      S_SEND_B: begin
        is_send = 1'b1; send_next = S_WAIT_ECHO_B;
        send_byte = {3'b000, pair_b[k[PW-1:0]]} + CH_A;
      end
      S_WAIT_ECHO_B: begin
        is_wait = 1'b1;
        if (pend) begin
          consume = 1'b1;
          if (rx_byte == tx_data) begin
            k_d = k + 8'd1;
            state_d = (k + 8'd1 == np_q) ? S_SEND_X : S_SEND_A;
          end else begin fail = 1'b1; fail_code = 3'd2; end
        end
      end
      S_SEND_X: begin is_send = 1'b1; send_byte = CH_X; send_next = S_WAIT_MENU1; end
      S_WAIT_MENU1: begin
        is_wait = 1'b1;
        if (pend) begin
          consume = 1'b1;
          if (rx_byte == CH_GT) state_d = S_SEND_S;
        end
      end
      S_SEND_S: begin is_send = 1'b1; send_byte = CH_S; send_next = S_WAIT_CRYPT; end
      S_WAIT_CRYPT: begin
        is_wait = 1'b1;
        if (pend) begin
          consume = 1'b1;
          if (rx_byte == CH_COLON) begin
            k_d = 8'd0;
            state_d = (tl_q == 8'd0) ? S_SEND_ESC : S_SEND_PT;
          end
        end
      end
      S_SEND_PT: begin
        is_send = 1'b1; send_next = S_WAIT_CT;
        send_byte = {3'b000, text_mem[k[LW-1:0]]} + CH_A;
      end
      S_WAIT_CT: begin
        is_wait = 1'b1;
        if (pend) begin
          consume = 1'b1;
          if (rx_byte >= CH_A && rx_byte <= CH_Z) begin
            ct_valid_d = 1'b1;
            ct_char_d  = 5'(rx_byte - CH_A);
            ct_idx_d   = k;
            k_d        = k + 8'd1;
            state_d    = (k + 8'd1 == tl_q) ? S_SEND_ESC : S_SEND_PT;
          end else begin fail = 1'b1; fail_code = 3'd3; end
        end
      end
      S_SEND_ESC: begin is_send = 1'b1; send_byte = CH_ESC; send_next = S_WAIT_MENU2; end
      S_WAIT_MENU2: begin
        is_wait = 1'b1;
        if (pend) begin
          consume = 1'b1;
          if (rx_byte == CH_GT) state_d = S_DONE;
        end
      end
      S_DONE: begin busy_d = 1'b0; done_d = 1'b1; state_d = S_IDLE; end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Shared transmit handshake: issue once the transmitter is idle, then
    // hold off until the byte has left the wire.
    if (is_send) begin
      if (!tx_sent) begin
        if (!tx_active) begin
          tx_start_d = 1'b1; tx_data_d = send_byte; tx_sent_d = 1'b1;
        end
      end else if (tx_done) begin
        tx_sent_d = 1'b0; state_d = send_next; cnt_d = '0;
      end
    end

    if (is_wait) begin
      if (consume) cnt_d = '0;
      else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin fail = 1'b1; fail_code = 3'd1; end
      else cnt_d = cnt + TW'(1);
    end
    if (new_rx) cnt_d = '0;

    if (fail) begin
      state_d = S_ERROR; err_code_d = fail_code; error_d = 1'b1; busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; k <= '0; np_q <= '0; tl_q <= '0; sync_q <= 1'b0;
      tx_sent <= 1'b0; cnt <= '0; rx_done_q <= 1'b0; pend <= 1'b0; rx_byte <= '0;
      tx_data <= '0; tx_start <= 1'b0; ct_valid <= 1'b0; ct_char <= '0; ct_idx <= '0;
      busy <= 1'b0; done <= 1'b0; error <= 1'b0; err_code <= '0;
    end else begin
      state <= state_d; k <= k_d; np_q <= np_d; tl_q <= tl_d; sync_q <= sync_d;
      tx_sent <= tx_sent_d; cnt <= cnt_d; rx_done_q <= rx_done;
      // A byte arriving while a send is still finishing stays pending here.
      pend <= new_rx | (pend & ~consume & ~clr_pend);
      if (new_rx) rx_byte <= rx_data;
      tx_data <= tx_data_d; tx_start <= tx_start_d; ct_valid <= ct_valid_d;
      ct_char <= ct_char_d; ct_idx <= ct_idx_d;
      busy <= busy_d; done <= done_d; error <= error_d; err_code <= err_code_d;
    end
  end
endmodule

// File: tb/tb_enigma_console_host.sv
// Bench for enigma_console_host: a small console model answers every byte
// the host sends (prompts, echoes, ciphertext) and the host's results are
// compared against hand-computed values.
module tb_enigma_console_host;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst_n, start, sync_menu, cfg_wr, cfg_sel;
  logic [7:0] cfg_idx, num_pairs, text_len;
  logic [4:0] cfg_a, cfg_b;
  logic [7:0] tx_data, rx_data, ct_idx;
  logic       tx_start, tx_active, tx_done, rx_done, ct_valid;
  logic [4:0] ct_char;
  logic       busy, done, error;
  logic [2:0] err_code;

  enigma_console_host #(.MAX_PAIRS(13), .MAX_LEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sync_menu(sync_menu),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .num_pairs(num_pairs), .text_len(text_len),
    .tx_data(tx_data), .tx_start(tx_start), .tx_active(tx_active), .tx_done(tx_done),
    .rx_data(rx_data), .rx_done(rx_done),
    .ct_valid(ct_valid), .ct_char(ct_char), .ct_idx(ct_idx),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int run_end_cyc = 0;
  logic [7:0] wire_log [$];
  logic [7:0] rxq [$];
  logic [7:0] ctq [$];
  int ct_chars [$];
  int ct_idxs [$];
  logic silent_p = 1'b0, bad_echo = 1'b0, bad_ct = 1'b0;
  logic plug_m = 1'b0, crypt_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (ct_valid === 1'b1) begin
    ct_chars.push_back(int'(ct_char));
    ct_idxs.push_back(int'(ct_idx));
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic respond(input logic [7:0] b);
    if (b == 8'h50) begin
      if (!silent_p) begin
        rxq.push_back(8'h0D); rxq.push_back(8'h0A); rxq.push_back(8'h3A);
        plug_m = 1'b1;
      end
    end else if (b == 8'h58) begin
      rxq.push_back(8'h0D); rxq.push_back(8'h0A); rxq.push_back(8'h3E);
      plug_m = 1'b0;
    end else if (b == 8'h53 && !crypt_m) begin
      rxq.push_back(8'h3A); crypt_m = 1'b1;
    end else if (b == 8'h1B) begin
      rxq.push_back(8'h0D); rxq.push_back(8'h0A); rxq.push_back(8'h3E);
      crypt_m = 1'b0;
    end else if (plug_m) begin
      rxq.push_back((bad_echo && b == 8'h42) ? 8'h51 : b);
    end else if (crypt_m) begin
      if (bad_ct) rxq.push_back(8'h3F);
      else if (ctq.size() > 0) rxq.push_back(ctq.pop_front());
      else rxq.push_back(8'h4E);
    end
  endtask

  // Transmitter model: busy for a few cycles, reply queued, then tx_done.
  initial begin
    logic [7:0] b;
    tx_active = 1'b0; tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        b = tx_data;
        wire_log.push_back(b);
        tx_active = 1'b1;
        repeat (4) @(negedge clk);
        tx_active = 1'b0;
        respond(b);
        @(negedge clk);
        tx_done = 1'b1; last_done_cyc = cyc;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Receiver model: one byte per rx_done pulse.
  initial begin
    rx_done = 1'b0; rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rxq.size() > 0) begin
        rx_data = rxq.pop_front();
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
      end
    end
  end

  task automatic cfg_write(input logic sel, input int idx, input int a, input int b);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_idx = 8'(idx); cfg_a = 5'(a); cfg_b = 5'(b);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic kick(input logic sm, input int np, input int tl);
    wire_log.delete(); ct_chars.delete(); ct_idxs.delete();
    plug_m = 1'b0; crypt_m = 1'b0;
    @(negedge clk);
    sync_menu = sm; num_pairs = 8'(np); text_len = 8'(tl); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (sm) begin rxq.push_back(8'h0D); rxq.push_back(8'h0A); rxq.push_back(8'h3E); end
  endtask

  task automatic run(input logic sm, input int np, input int tl);
    int n;
    kick(sm, np, tl);
    n = 0;
    while (!(done || error) && n < 20000) begin @(negedge clk); n++; end
    run_end_cyc = cyc;
    check("run_finished", int'(n < 20000), 1);
  endtask

  function automatic int all_outs();
    return int'({tx_data, tx_start, ct_valid, ct_char, ct_idx, busy, done, error, err_code});
  endfunction

  logic [7:0] exp1 [5] = '{8'h53, 8'h41, 8'h41, 8'h41, 8'h1B};
  logic [7:0] exp2 [9] = '{8'h50, 8'h41, 8'h42, 8'h43, 8'h44, 8'h58, 8'h53, 8'h41, 8'h1B};

  initial begin
    int n, cnt;
    rst_n = 1'b1; start = 1'b0; sync_menu = 1'b0; cfg_wr = 1'b0; cfg_sel = 1'b0;
    cfg_idx = 8'd0; cfg_a = 5'd0; cfg_b = 5'd0; num_pairs = 8'd0; text_len = 8'd0;
    #3 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;

    // Encrypt AAA with menu sync, console answers B D Z.
    for (int i = 0; i < 3; i++) cfg_write(1'b1, i, 0, 0);
    ctq.push_back(8'h42); ctq.push_back(8'h44); ctq.push_back(8'h5A);
    run(1'b1, 0, 3);
    check("t1_ct_count", ct_chars.size(), 3);
    check("t1_ct0", ct_chars[0], 1);  check("t1_ct1", ct_chars[1], 3);  check("t1_ct2", ct_chars[2], 25);
    check("t1_idx0", ct_idxs[0], 0);  check("t1_idx1", ct_idxs[1], 1);  check("t1_idx2", ct_idxs[2], 2);
    check("t1_wire_len", wire_log.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("t1_wire%0d", i), int'(wire_log[i]), int'(exp1[i]));
    check("t1_done", int'(done), 1);
    check("t1_error", int'(error), 0);
    check("t1_busy", int'(busy), 0);

    // Two pairs A-B, C-D, one letter.
    cfg_write(1'b0, 0, 0, 1);
    cfg_write(1'b0, 1, 2, 3);
    run(1'b0, 2, 1);
    check("t2_wire_len", wire_log.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("t2_wire%0d", i), int'(wire_log[i]), int'(exp2[i]));
    check("t2_done", int'(done), 1);
    check("t2_ct", ct_chars.size() > 0 ? ct_chars[0] : -1, 13);

    // Wrong echo for 'B'.
    bad_echo = 1'b1;
    run(1'b0, 2, 1);
    bad_echo = 1'b0;
    check("t3_error", int'(error), 1);
    check("t3_code", int'(err_code), 2);
    check("t3_wire_len", wire_log.size(), 3);
    check("t3_done", int'(done), 0);

    // Silent console after 'P'.
    silent_p = 1'b1;
    run(1'b0, 2, 1);
    silent_p = 1'b0;
    check("t4_error", int'(error), 1);
    check("t4_code", int'(err_code), 1);
    check("t4_latency", run_end_cyc - last_done_cyc, TMO + 1);
    check("t4_wire_len", wire_log.size(), 1);
    repeat (10) @(negedge clk);

    // Non-letter ciphertext.
    bad_ct = 1'b1;
    run(1'b0, 0, 2);
    bad_ct = 1'b0;
    check("t5_code", int'(err_code), 3);
    check("t5_wire_len", wire_log.size(), 2);
    check("t5_ct_count", ct_chars.size(), 0);
    repeat (10) @(negedge clk);

    // Bad configurations.
    run(1'b0, 20, 1);
    check("t6_np_code", int'(err_code), 4);
    check("t6_np_wire", wire_log.size(), 0);
    run(1'b0, 0, 40);
    check("t6_tl_code", int'(err_code), 4);
    cfg_write(1'b0, 1, 26, 3);
    run(1'b0, 2, 1);
    check("t6_letter_code", int'(err_code), 4);
    check("t6_letter_wire", wire_log.size(), 0);
    cfg_write(1'b0, 1, 2, 3);

    // Reset in the middle of the pair exchange, then a clean rerun.
    kick(1'b0, 2, 1);
    n = 0;
    while (wire_log.size() < 3 && n < 2000) begin @(negedge clk); n++; end
    check("t7_reached_pair", int'(n < 2000), 1);
    rst_n = 1'b0;
    #1;
    check("t7_reset_outputs", all_outs(), 0);
    repeat (20) @(negedge clk);
    rxq.delete();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (tx_start === 1'b1) cnt++; end
    check("t7_quiet_tx", cnt, 0);
    check("t7_busy", int'(busy), 0);
    run(1'b0, 2, 1);
    check("t7_done", int'(done), 1);
    check("t7_wire_len", wire_log.size(), 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
